// File: rtl/button_bank_channel.sv
`default_nettype none
// ============================================================================
// Module   : button_bank_channel
// Purpose  : One button: 2-flop synchroniser, hysteresis debouncer, edge and
//            auto-repeat strobes.
// Revision : 1.0
// ============================================================================
module button_bank_channel #(
    parameter int NUM_SAMPLES    = 5,
    parameter int HOLD_SAMPLES   = 64,
    parameter int REPEAT_SAMPLES = 16
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_en,
    input  logic i_sample_stb,
    input  logic i_button,
    output logic o_state,
    output logic o_press_stb,
    output logic o_release_stb,
    output logic o_repeat_stb
);

    localparam int CNT_W = $clog2(HOLD_SAMPLES + 1);
    localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(HOLD_SAMPLES - 1);
    localparam logic [CNT_W-1:0] C_RELOAD    = CNT_W'(HOLD_SAMPLES - REPEAT_SAMPLES);

    logic                   sync1_q, sync1_d;
    logic                   sync2_q, sync2_d;
    logic [NUM_SAMPLES-1:0] samples_q, samples_d;
    logic                   state_q, state_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   repeat_q, repeat_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    always_comb begin
        sync1_d   = sync1_q;
        sync2_d   = sync2_q;
        samples_d = samples_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        repeat_d  = 1'b0;
        if (i_en) begin
            sync1_d = i_button;
            sync2_d = sync1_q;
            if (i_sample_stb) begin
                samples_d = {samples_q[NUM_SAMPLES-2:0], sync2_q};
                if (&samples_d) begin
                    state_d = 1'b1;
                end else if (~|samples_d) begin
                    state_d = 1'b0;
                end
            end
            press_d   = state_d & ~state_q;
            release_d = ~state_d & state_q;
            // Only strobes seen while already held advance the hold count.
            if (!state_d) begin
                cnt_d = '0;
            end else if (state_q && i_sample_stb) begin
                if (cnt_q == C_HOLD_LAST) begin
                    repeat_d = 1'b1;
                    cnt_d    = C_RELOAD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            samples_q <= '0;
            state_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            samples_q <= samples_d;
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_state       = state_q;
    assign o_press_stb   = press_q;
    assign o_release_stb = release_q;
    assign o_repeat_stb  = repeat_q;

endmodule
`default_nettype wire

// File: rtl/button_bank.sv
`default_nettype none
// ============================================================================
// Module   : button_bank
// Purpose  : NUM_BUTTONS independent debounced button channels sharing one
//            enable and sample strobe.
// Revision : 1.0
// ============================================================================
module button_bank #(
    parameter int NUM_BUTTONS    = 3,
    parameter int NUM_SAMPLES    = 5,
    parameter int HOLD_SAMPLES   = 64,
    parameter int REPEAT_SAMPLES = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_en,
    input  logic                   i_sample_stb,
    input  logic [NUM_BUTTONS-1:0] i_buttons,
    output logic [NUM_BUTTONS-1:0] o_state,
    output logic [NUM_BUTTONS-1:0] o_press_stb,
    output logic [NUM_BUTTONS-1:0] o_release_stb,
    output logic [NUM_BUTTONS-1:0] o_repeat_stb
);

    for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_chan
        button_bank_channel #(
            .NUM_SAMPLES   (NUM_SAMPLES),
            .HOLD_SAMPLES  (HOLD_SAMPLES),
            .REPEAT_SAMPLES(REPEAT_SAMPLES)
        ) u_chan (
            .i_clk         (i_clk),
            .i_reset_n     (i_reset_n),
            .i_en          (i_en),
            .i_sample_stb  (i_sample_stb),
            .i_button      (i_buttons[gi]),
            .o_state       (o_state[gi]),
            .o_press_stb   (o_press_stb[gi]),
            .o_release_stb (o_release_stb[gi]),
            .o_repeat_stb  (o_repeat_stb[gi])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_button_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_bank
// Purpose  : Randomised scoreboard bench for button_bank against an
//            event-level reference model.
// Revision : 1.0
// ============================================================================
module tb_button_bank;

    localparam int NB   = 3;
    localparam int NS   = 5;
    localparam int HOLD = 64;
    localparam int REP  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          stb = 1'b0;
    logic [NB-1:0] btn = '0;
    logic [NB-1:0] o_state, o_press, o_rel, o_rep;

    button_bank #(
        .NUM_BUTTONS(NB), .NUM_SAMPLES(NS), .HOLD_SAMPLES(HOLD), .REPEAT_SAMPLES(REP)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_en(en), .i_sample_stb(stb),
        .i_buttons(btn), .o_state(o_state), .o_press_stb(o_press),
        .o_release_stb(o_rel), .o_repeat_stb(o_rep)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [NB-1:0] pr;
        logic [NB-1:0] rl;
        logic [NB-1:0] rp;
    } ev_t;

    ev_t           exp_q[$];
    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;
    int            rep1_count = 0;
    bit            count_rep1 = 1'b0;

    // Reference model: raw level seen two enabled clocks later, run lengths of
    // agreeing samples, and number of held strobes since the press.
    bit            pipe0[NB], pipe1[NB];
    int            ones_run[NB], zeros_run[NB], held[NB];
    logic [NB-1:0] mst = '0;

    always @(posedge clk) begin
        logic [NB-1:0] pr, rl, rp;
        bit            delayed, ns;
        cyc++;
        pr = '0; rl = '0; rp = '0;
        if (!rst_n) begin
            for (int c = 0; c < NB; c++) begin
                pipe0[c] = 0; pipe1[c] = 0;
                ones_run[c] = 0; zeros_run[c] = NS; held[c] = 0;
            end
            mst = '0;
        end else if (en) begin
            for (int c = 0; c < NB; c++) begin
                delayed  = pipe1[c];
                pipe1[c] = pipe0[c];
                pipe0[c] = btn[c];
                if (stb) begin
                    if (delayed) begin ones_run[c]++; zeros_run[c] = 0; end
                    else begin zeros_run[c]++; ones_run[c] = 0; end
                    ns = mst[c];
                    if (ones_run[c] >= NS) ns = 1;
                    else if (zeros_run[c] >= NS) ns = 0;
                    if (ns && !mst[c]) pr[c] = 1'b1;
                    if (!ns && mst[c]) rl[c] = 1'b1;
                    if (ns && mst[c]) begin
                        held[c]++;
                        if (held[c] >= HOLD && (held[c] - HOLD) % REP == 0) rp[c] = 1'b1;
                    end else begin
                        held[c] = 0;
                    end
                    mst[c] = ns;
                end
            end
            if ((pr | rl | rp) != '0) exp_q.push_back('{cyc, pr, rl, rp});
        end
    end

    always @(negedge clk) begin
        ev_t e;
        bit  exp_here;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            tests++; fails++;
            $display("FAIL missed_strobe cyc %0d: got none, want press %b release %b repeat %b",
                     e.cyc, e.pr, e.rl, e.rp);
        end
        exp_here = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
        if (((o_press | o_rel | o_rep) != '0) || exp_here) begin
            tests++;
            if (!exp_here) begin
                fails++;
                $display("FAIL unexpected_strobe cyc %0d: got press %b release %b repeat %b, want none",
                         cyc, o_press, o_rel, o_rep);
            end else begin
                e = exp_q.pop_front();
                if (o_press !== e.pr || o_rel !== e.rl || o_rep !== e.rp) begin
                    fails++;
                    $display("FAIL strobe_value cyc %0d: got press %b release %b repeat %b, want %b %b %b",
                             cyc, o_press, o_rel, o_rep, e.pr, e.rl, e.rp);
                end
            end
        end
        if (count_rep1 && o_rep[1] === 1'b1) rep1_count++;
        tests++;
        if (o_state !== mst) begin
            fails++;
            $display("FAIL state cyc %0d: got %b want %b", cyc, o_state, mst);
        end
    end

    int stb_ctr = 0;
    int stb_period = 3;

    task automatic step(input logic [NB-1:0] b, input logic e_n, input logic r_n);
        @(negedge clk);
        btn   = b;
        en    = e_n;
        rst_n = r_n;
        stb   = (stb_ctr == 0);
        stb_ctr = (stb_ctr + 1) % stb_period;
    endtask

    task automatic run(input logic [NB-1:0] b, input int n);
        for (int k = 0; k < n; k++) step(b, 1'b1, 1'b1);
    endtask

    task automatic check_zero(input string name);
        tests++;
        if ((o_state | o_press | o_rel | o_rep) !== '0) begin
            fails++;
            $display("FAIL %s: got state %b press %b release %b repeat %b, want all 0",
                     name, o_state, o_press, o_rel, o_rep);
        end
    endtask

    initial begin
        logic [NB-1:0] b;
        // Reset with all buttons held, then release into a press on all channels.
        for (int k = 0; k < 5; k++) step(3'b111, 1'b1, 1'b0);
        @(posedge clk); #1;
        check_zero("reset_outputs");
        run(3'b111, 30);
        run(3'b000, 30);

        // Channel 0 press with one low glitch during the debounce window.
        run(3'b001, 6);
        run(3'b000, 1);
        run(3'b001, 30);
        // Glitch while held must not release.
        run(3'b000, 1);
        run(3'b001, 20);
        run(3'b000, 30);

        // Long hold on channel 1: three repeats expected.
        count_rep1 = 1'b1;
        run(3'b010, 330);
        count_rep1 = 1'b0;
        tests++;
        if (rep1_count != 3) begin
            fails++;
            $display("FAIL hold_repeat_count: got %0d repeats want 3", rep1_count);
        end
        run(3'b000, 30);

        // Enable dropped mid-debounce while inputs toggle.
        run(3'b101, 8);
        for (int k = 0; k < 20; k++) step(NB'($urandom), 1'b0, 1'b1);
        run(3'b101, 40);
        run(3'b000, 40);

        // Reset while channel 2 is repeating, then keep holding.
        run(3'b100, 260);
        step(3'b100, 1'b1, 1'b0);
        @(posedge clk); #1;
        check_zero("reset_mid_hold");
        step(3'b100, 1'b1, 1'b0);
        run(3'b100, 300);
        run(3'b000, 30);

        // Randomised traffic: bouncing inputs, enable gaps, strobe jitter, resets.
        b = '0;
        for (int k = 0; k < 3000; k++) begin
            logic e_n, r_n;
            if ($urandom_range(0, 15) == 0) b = b ^ NB'($urandom);
            stb_period = ($urandom_range(0, 99) < 10) ? 2 : 3;
            e_n = ($urandom_range(0, 19) != 0);
            r_n = ($urandom_range(0, 999) != 0);
            step(b, e_n, r_n);
        end
        run(3'b000, 40);

        @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending events want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_bank.md
# button_bank

Multi-channel button conditioner for the desk-clock user interface: synchronises N raw push-button inputs, debounces each with symmetric hysteresis, and produces per-channel level, press, release and auto-repeat strobes. It sits between the board pins and the clock-setting control FSM and is paced by the shared slow sample strobe. Auto-repeat lets a held button step hours or minutes at a steady rate.

## Interface

- NUM_BUTTONS, 3, number of independent channels (≥1)
- NUM_SAMPLES, 5, consecutive agreeing samples required to change debounced state (≥2)
- HOLD_SAMPLES, 64, sample strobes a button must stay debounced-high before the first repeat strobe (≥1)
- REPEAT_SAMPLES, 16, sample strobes between subsequent repeat strobes (1 ≤ REPEAT_SAMPLES ≤ HOLD_SAMPLES)

- i_clk, in, 1, system clock
- i_reset_n, in, 1, synchronous, active-low reset
- i_en, in, 1, global enable; low freezes all state and forces strobes low
- i_sample_stb, in, 1, one-cycle debounce sample tick
- i_buttons, in, NUM_BUTTONS, raw asynchronous button levels (1 = pressed)
- o_state, out, NUM_BUTTONS, debounced level per channel
- o_press_stb, out, NUM_BUTTONS, one-cycle pulse on debounced 0→1
- o_release_stb, out, NUM_BUTTONS, one-cycle pulse on debounced 1→0
- o_repeat_stb, out, NUM_BUTTONS, one-cycle auto-repeat pulse while held

## Operation

- Reset: all synchronisers, sample shift registers, o_state, hold counters and all strobes = 0.
- Synchroniser: per channel, 2-flop chain advanced on every clock with i_en=1.
- Sampling: on i_en & i_sample_stb, shift synchroniser output into an NUM_SAMPLES-bit register.
- Debounce with hysteresis: all sample bits 1 → state 1; all 0 → state 0; mixed → state holds. A single glitch sample never changes state in either direction.
- Edge strobes: o_press_stb[i] high for exactly the one clock in which o_state[i] first reads 1; o_release_stb[i] likewise for first 0. Never both in the same cycle on one channel.
- Hold counter, per channel, width $clog2(HOLD_SAMPLES+1): cleared whenever o_state[i]=0; incremented on each i_en & i_sample_stb while o_state[i]=1.
- Repeat: when the counter reaches HOLD_SAMPLES, pulse o_repeat_stb[i] for one clock and reload counter to HOLD_SAMPLES−REPEAT_SAMPLES; pattern repeats every REPEAT_SAMPLES strobes until release. Counter never wraps.
- Channels are fully independent; simultaneous events on several channels all strobe in the same cycle.
- i_en low: no register changes, all strobes 0; resuming i_en continues from frozen state without spurious strobes.

## Timing

- Raw edge → synchronised: 2 enabled clocks.
- Debounced change: clock after the sample strobe that makes the register unanimous; worst case NUM_SAMPLES strobes + 3 clocks after a clean input edge.
- Strobes: registered, aligned to the first cycle of new o_state (press/release) or the clock after the qualifying sample strobe (repeat).
- First repeat: HOLD_SAMPLES strobes after press, counting only strobes where o_state=1 before the edge.
- Reset mid-hold: outputs 0 next clock, no release strobe emitted.

## Structure

- No shared package needed; counter width derived locally via localparam.
- One sub-module natural: button_bank_channel (sync + samples + state + hold counter for one button), instanced NUM_BUTTONS times in a generate loop; top level only fans out i_en/i_sample_stb and concatenates outputs.

## Test plan

- Reset with i_buttons=3'b111 held → all outputs 0 during reset; after release, o_state=3'b111 after 5 strobes + ≤3 clocks, o_press_stb=3'b111 for one clock.
- Channel 0 pressed, one low sample inserted at strobe 3 → no state change; then 5 clean high samples → single press strobe.
- Pressed channel with one low glitch sample → o_state stays 1, no release strobe (hysteresis check).
- Hold channel 1 for 100 strobes (HOLD=64, REPEAT=16) → repeat strobes after strobes 64 and 80 and 96 only; release → one o_release_stb, counter cleared.
- i_en low for 20 clocks mid-debounce with input toggling → no output change; resumes exactly where frozen.
- Assert reset while channel 2 is repeating → outputs 0 next clock, no release strobe, no repeat after reset deasserts until a fresh full hold.
